// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor with borrow/overflow/zero flags
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] nb_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             a_msb;
  logic             b_msb;

  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] r_next;

  // One full-adder stage: a + ~b + carry, plus the result register as it will look after this bit
  always_comb begin
    s      = a_sr[0] ^ nb_sr[0] ^ c;
    c_next = (a_sr[0] & nb_sr[0]) | (c & (a_sr[0] ^ nb_sr[0]));
    r_next = {s, r_sr[WIDTH-1:1]};
  end

  // Control FSM and serial datapath; outputs are registered and only move on entry to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      nb_sr    <= '0;
      r_sr     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            nb_sr <= ~b;
            c     <= 1'b1;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          nb_sr <= nb_sr >> 1;
          r_sr  <= r_next;
          c     <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            y        <= r_next;
            borrow   <= ~c_next;
            overflow <= (a_msb ^ b_msb) & (r_next[WIDTH-1] ^ a_msb);
            zero     <= (r_next == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         borrow;
  logic         overflow;
  logic         zero;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ey;
    logic         eb;
    logic         eo;
    logic         ez;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         bo;
    logic         ov;
    logic         ze;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] z);
    res_t   r;
    longint d;
    d    = longint'($signed(x)) - longint'($signed(z));
    r.y  = x - z;
    r.bo = (x < z);
    r.ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    r.ze = (r.y == '0);
    return r;
  endfunction

  // One operation from IDLE; reports result, done latency (edges after accept) and busy cycles
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        output res_t r, output int lat, output int busyc);
    logic [W-1:0] prev_y;
    int           unstable;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    prev_y = y; lat = 0; busyc = 0; unstable = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) busyc++;
      if (done) begin
        lat = n;
        break;
      end
      if (y !== prev_y) unstable++;
    end
    check("y_stable_during_run", 64'(unstable), 64'd0);
    r.y = y; r.bo = borrow; r.ov = overflow; r.ze = zero;
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  vec_t  vecs[8];
  res_t  r, m;
  int    lat, busyc, extra;
  logic [W-1:0] ha[200];
  logic [W-1:0] hb[200];
  int    last_done, ndone;

  initial begin
    vecs[0] = '{32'd5,          32'd3,          32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd3,          32'd5,          32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000,   32'd1,          32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h12345678,   32'h12345678,   32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'd0,          32'd1,          32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h80000000,   32'h80000000,   32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h00000000,   32'h80000000,   32'h80000000, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {58'd0, busy, done, borrow, overflow, zero, |y}, 64'd0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, r, lat, busyc);
      check($sformatf("vec%0d_y", i), 64'(r.y), 64'(vecs[i].ey));
      check($sformatf("vec%0d_flags", i), {61'd0, r.bo, r.ov, r.ze},
            {61'd0, vecs[i].eb, vecs[i].eo, vecs[i].ez});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busyc), 64'(W));
    end

    // start and operand changes during RUN must not disturb the result or add a done
    @(negedge clk);
    a = 32'h12345678; b = 32'h12345678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a = 32'd1 + i; b = 32'd77; start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = 1;
        break;
      end
    end
    check("midrun_done_seen", 64'(lat), 64'd1);
    check("midrun_y", 64'(y), 64'd0);
    check("midrun_zero", {63'd0, zero}, 64'd1);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrun_no_extra_done", 64'(extra), 64'd0);

    // Asynchronous reset mid-RUN
    run_op(32'd3, 32'd5, r, lat, busyc);
    @(negedge clk);
    a = 32'd100; b = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, busy, done, borrow, overflow, zero, y}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("no_done_after_abort", 64'(extra), 64'd0);
    run_op(32'd10, 32'd4, r, lat, busyc);
    check("post_reset_y", 64'(r.y), 64'd6);
    check("post_reset_latency", 64'(lat), 64'(W + 1));

    // start held high: one result per W+2 cycles, for operands present at each accept edge
    last_done = -1; ndone = 0;
    for (int i = 0; i < 4 * (W + 2) + 4; i++) begin
      @(negedge clk);
      if (done) begin
        m = model(ha[i - 1 - W], hb[i - 1 - W]);
        check($sformatf("cont%0d_y", ndone), 64'(y), 64'(m.y));
        check($sformatf("cont%0d_flags", ndone), {61'd0, borrow, overflow, zero},
              {61'd0, m.bo, m.ov, m.ze});
        if (last_done >= 0) check($sformatf("cont%0d_period", ndone), 64'(i - last_done), 64'(W + 2));
        else check("cont_first_latency", 64'(i), 64'(W + 1));
        last_done = i;
        ndone++;
      end
      a = $urandom; b = $urandom; start = 1'b1;
      ha[i] = a; hb[i] = b;
    end
    start = 1'b0;
    check("cont_done_count", 64'(ndone), 64'd4);
    repeat (W + 4) @(negedge clk);

    // Random vectors against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 10 == 0) ? ra : $urandom;
      if (i % 17 == 0) rb = {1'b1, ra[W-2:0]};
      run_op(ra, rb, r, lat, busyc);
      m = model(ra, rb);
      check($sformatf("rand%0d_y", i), 64'(r.y), 64'(m.y));
      check($sformatf("rand%0d_flags", i), {61'd0, r.bo, r.ov, r.ze}, {61'd0, m.bo, m.ov, m.ze});
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(W + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
